// File: rtl/video_writer.sv
// Text-screen write engine: turns SETCURSOR/PUTCHAR/FILL/CLEAR commands into
// masked cell writes on the video memory port, one cell per clock.
//
// state  | meaning
// S_IDLE | accepting commands; SETCURSOR/PUTCHAR complete here in one cycle
// S_FILL | walking a rectangle row-major, one write per cycle
module video_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 25,
  parameter int ATTR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [15:0]       cmd_x,
  input  logic [15:0]       cmd_y,
  input  logic [15:0]       cmd_w,
  input  logic [15:0]       cmd_h,
  input  logic [ATTR_W-1:0] cmd_value,
  input  logic [ATTR_W-1:0] cmd_mask,
  output logic [15:0]       cursor_x,
  output logic [15:0]       cursor_y,
  output logic              busy,
  output logic              video_write,
  output logic [15:0]       video_address,
  output logic [ATTR_W-1:0] video_value,
  output logic [ATTR_W-1:0] video_mask
);

  localparam logic [1:0]  OP_SETCURSOR = 2'd0;
  localparam logic [1:0]  OP_PUTCHAR   = 2'd1;
  localparam logic [1:0]  OP_FILL      = 2'd2;
  localparam logic [1:0]  OP_CLEAR     = 2'd3;

  localparam logic [15:0] COLS16 = 16'(COLS);
  localparam logic [15:0] ROWS16 = 16'(ROWS);
  localparam logic [15:0] X_MAX  = 16'(COLS - 1);
  localparam logic [15:0] Y_MAX  = 16'(ROWS - 1);
  localparam logic [16:0] COLS17 = 17'(COLS);
  localparam logic [16:0] ROWS17 = 17'(ROWS);

  typedef enum logic [0:0] {S_IDLE, S_FILL} state_t;

  state_t state_q, state_d;

  logic [15:0] fx_q, fx_d, fy_q, fy_d;
  logic [15:0] x0_q, x0_d, x_last_q, x_last_d, y_last_q, y_last_d;
  logic [15:0] row_base_q, row_base_d;
  logic [15:0] cur_x_d, cur_y_d, addr_d;
  logic [ATTR_W-1:0] value_d, mask_d;
  logic        write_d, busy_d;

  logic [16:0] x_sum, y_sum;
  logic [15:0] cmd_x_last, cmd_y_last, cur_addr, fill_base;
  logic        fill_empty;

  // Rectangle bounds are kept as inclusive last coordinates, clipped to the screen.
  assign x_sum      = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign y_sum      = {1'b0, cmd_y} + {1'b0, cmd_h};
  assign cmd_x_last = (x_sum >= COLS17) ? X_MAX : (x_sum[15:0] - 16'd1);
  assign cmd_y_last = (y_sum >= ROWS17) ? Y_MAX : (y_sum[15:0] - 16'd1);
  assign fill_empty = (cmd_w == 16'd0) || (cmd_h == 16'd0) ||
                      (cmd_x >= COLS16) || (cmd_y >= ROWS16);
  assign cur_addr   = cursor_y * COLS16 + cursor_x;
  assign fill_base  = cmd_y * COLS16;

  assign cmd_ready  = (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    x0_d       = x0_q;
    x_last_d   = x_last_q;
    y_last_d   = y_last_q;
    row_base_d = row_base_q;
    cur_x_d    = cursor_x;
    cur_y_d    = cursor_y;
    addr_d     = video_address;
    value_d    = video_value;
    mask_d     = video_mask;
    write_d    = 1'b0;
    busy_d     = busy;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (cmd_valid) begin
          case (cmd_op)
            OP_SETCURSOR: begin
              cur_x_d = (cmd_x > X_MAX) ? X_MAX : cmd_x;
              cur_y_d = (cmd_y > Y_MAX) ? Y_MAX : cmd_y;
            end
            OP_PUTCHAR: begin
              write_d = 1'b1;
              addr_d  = cur_addr;
              value_d = cmd_value;
              mask_d  = cmd_mask;
              if (cursor_x >= X_MAX) begin
                cur_x_d = 16'd0;
                cur_y_d = (cursor_y >= Y_MAX) ? 16'd0 : cursor_y + 16'd1;
              end else begin
                cur_x_d = cursor_x + 16'd1;
              end
            end
            OP_FILL: begin
              if (!fill_empty) begin
                state_d    = S_FILL;
                busy_d     = 1'b1;
                fx_d       = cmd_x;
                fy_d       = cmd_y;
                x0_d       = cmd_x;
                x_last_d   = cmd_x_last;
                y_last_d   = cmd_y_last;
                row_base_d = fill_base;
                value_d    = cmd_value;
                mask_d     = cmd_mask;
              end
            end
            default: begin
              state_d    = S_FILL;
              busy_d     = 1'b1;
              fx_d       = 16'd0;
              fy_d       = 16'd0;
              x0_d       = 16'd0;
              x_last_d   = X_MAX;
              y_last_d   = Y_MAX;
              row_base_d = 16'd0;
              value_d    = cmd_value;
              mask_d     = cmd_mask;
              cur_x_d    = 16'd0;
              cur_y_d    = 16'd0;
            end
          endcase
        end
      end
      S_FILL: begin
        write_d = 1'b1;
        addr_d  = row_base_q + fx_q;
        if (fx_q == x_last_q) begin
          fx_d       = x0_q;
          fy_d       = fy_q + 16'd1;
          row_base_d = row_base_q + COLS16;
          if (fy_q == y_last_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          fx_d = fx_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      fx_q          <= '0;
      fy_q          <= '0;
      x0_q          <= '0;
      x_last_q      <= '0;
      y_last_q      <= '0;
      row_base_q    <= '0;
      cursor_x      <= '0;
      cursor_y      <= '0;
      busy          <= 1'b0;
      video_write   <= 1'b0;
      video_address <= '0;
      video_value   <= '0;
      video_mask    <= '0;
    end else begin
      state_q       <= state_d;
      fx_q          <= fx_d;
      fy_q          <= fy_d;
      x0_q          <= x0_d;
      x_last_q      <= x_last_d;
      y_last_q      <= y_last_d;
      row_base_q    <= row_base_d;
      cursor_x      <= cur_x_d;
      cursor_y      <= cur_y_d;
      busy          <= busy_d;
      video_write   <= write_d;
      video_address <= addr_d;
      video_value   <= value_d;
      video_mask    <= mask_d;
    end
  end

endmodule

// File: tb/tb_video_writer.sv
// Bench for video_writer: directed screen scenarios plus random commands,
// each compared against a cell-list model of the text screen.
module tb_video_writer;
  localparam int COLS = 80;
  localparam int ROWS = 25;
  localparam int AW   = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [15:0]   cmd_x, cmd_y, cmd_w, cmd_h;
  logic [AW-1:0] cmd_value, cmd_mask;
  logic [15:0]   cursor_x, cursor_y;
  logic          busy, video_write;
  logic [15:0]   video_address;
  logic [AW-1:0] video_value, video_mask;

  always #5 clk = ~clk;

  video_writer #(.COLS(COLS), .ROWS(ROWS), .ATTR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_value(cmd_value), .cmd_mask(cmd_mask),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy),
    .video_write(video_write), .video_address(video_address),
    .video_value(video_value), .video_mask(video_mask)
  );

  typedef struct {
    int            addr;
    logic [AW-1:0] val;
    logic [AW-1:0] msk;
    int            cyc;
    logic          bsy;
    logic          rdy;
  } wr_t;

  wr_t act[$];
  int  exp_q[$];
  int  m_cx, m_cy;
  int  cyc, checks, errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (reset && video_write) begin
      wr_t w;
      w.addr = int'(video_address);
      w.val  = video_value;
      w.msk  = video_mask;
      w.cyc  = cyc;
      w.bsy  = busy;
      w.rdy  = cmd_ready;
      act.push_back(w);
    end
  endtask

  // Screen model: cells touched by a command, listed in write order.
  task automatic model(input int op, input int x, input int y, input int w, input int h);
    case (op)
      0: begin
        m_cx = (x > COLS - 1) ? COLS - 1 : x;
        m_cy = (y > ROWS - 1) ? ROWS - 1 : y;
      end
      1: begin
        exp_q.push_back(m_cy * COLS + m_cx);
        m_cx++;
        if (m_cx == COLS) begin
          m_cx = 0;
          m_cy = (m_cy + 1) % ROWS;
        end
      end
      2: begin
        if (w != 0 && h != 0 && x < COLS && y < ROWS) begin
          int xe, ye;
          xe = (x + w > COLS) ? COLS : x + w;
          ye = (y + h > ROWS) ? ROWS : y + h;
          for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++)
              exp_q.push_back(yy * COLS + xx);
        end
      end
      default: begin
        for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back(a);
        m_cx = 0;
        m_cy = 0;
      end
    endcase
  endtask

  task automatic send(input int op, input int x, input int y, input int w, input int h,
                      input logic [AW-1:0] v, input logic [AW-1:0] m);
    int n;
    cmd_op    = 2'(op);
    cmd_x     = 16'(x);
    cmd_y     = 16'(y);
    cmd_w     = 16'(w);
    cmd_h     = 16'(h);
    cmd_value = v;
    cmd_mask  = m;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) chk("accept_timeout", 64'(n), 64'(0));
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 64'(n), 64'(0));
  endtask

  task automatic compare(input string tag, input logic [AW-1:0] v, input logic [AW-1:0] m,
                         input bit fillish);
    int n;
    n = (act.size() < exp_q.size()) ? act.size() : exp_q.size();
    chk({tag, "_count"}, 64'(act.size()), 64'(exp_q.size()));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, 64'(act[i].addr), 64'(exp_q[i]));
      chk({tag, "_value"}, 64'(act[i].val), 64'(v));
      chk({tag, "_mask"}, 64'(act[i].msk), 64'(m));
      if (i > 0) chk({tag, "_consecutive"}, 64'(act[i].cyc), 64'(act[0].cyc + i));
      if (fillish) begin
        chk({tag, "_busy"}, 64'(act[i].bsy), 64'(i != exp_q.size() - 1));
        chk({tag, "_ready"}, 64'(act[i].rdy), 64'(i == exp_q.size() - 1));
      end else begin
        chk({tag, "_busy"}, 64'(act[i].bsy), 64'(0));
        chk({tag, "_ready"}, 64'(act[i].rdy), 64'(1));
      end
    end
    chk({tag, "_cursor_x"}, 64'(cursor_x), 64'(m_cx));
    chk({tag, "_cursor_y"}, 64'(cursor_y), 64'(m_cy));
  endtask

  task automatic run(input string tag, input int op, input int x, input int y, input int w,
                     input int h, input logic [AW-1:0] v, input logic [AW-1:0] m);
    act.delete();
    exp_q.delete();
    model(op, x, y, w, h);
    send(op, x, y, w, h, v, m);
    wait_idle();
    step();
    step();
    compare(tag, v, m, op >= 2);
  endtask

  initial begin
    int n;
    logic [AW-1:0] rv, rm;
    checks = 0; errors = 0; cyc = 0;
    m_cx = 0; m_cy = 0;
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_value = '0; cmd_mask = '0;
    repeat (3) step();
    chk("rst_write", 64'(video_write), 64'(0));
    chk("rst_addr", 64'(video_address), 64'(0));
    chk("rst_value", 64'(video_value), 64'(0));
    chk("rst_mask", 64'(video_mask), 64'(0));
    chk("rst_cursor", 64'({cursor_x, cursor_y}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    reset = 1'b1;
    step();

    // Cursor placement and back-to-back PUTCHAR
    run("setcur_5_2", 0, 5, 2, 0, 0, '0, '0);
    act.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      model(1, 0, 0, 0, 0);
      send(1, 0, 0, 0, 0, 24'h000041, 24'hFFFFFF);
    end
    step();
    step();
    compare("put3", 24'h000041, 24'hFFFFFF, 1'b0);
    if (act.size() == 3) begin
      chk("put3_a0", 64'(act[0].addr), 64'(165));
      chk("put3_a2", 64'(act[2].addr), 64'(167));
    end
    chk("put3_cursor", 64'({cursor_x, cursor_y}), 64'({16'd8, 16'd2}));

    // Screen corner wrap and clamping
    run("setcur_corner", 0, 79, 24, 0, 0, '0, '0);
    run("put_corner", 1, 0, 0, 0, 0, 24'h123456, 24'h0F0F0F);
    if (act.size() == 1) chk("put_corner_addr", 64'(act[0].addr), 64'(1999));
    run("setcur_clamp", 0, 200, 90, 0, 0, '0, '0);
    chk("clamp_cursor", 64'({cursor_x, cursor_y}), 64'({16'd79, 16'd24}));

    // Clipped FILL at the bottom-right corner
    run("fill_clip", 2, 78, 23, 5, 5, 24'hABCDEF, 24'h00FF00);
    if (act.size() == 4) begin
      chk("fill_clip_a0", 64'(act[0].addr), 64'(1918));
      chk("fill_clip_a3", 64'(act[3].addr), 64'(1999));
    end

    // Degenerate FILLs
    run("fill_w0", 2, 10, 10, 0, 3, 24'h1, 24'h1);
    chk("fill_w0_ready", 64'(cmd_ready), 64'(1));
    run("fill_x80", 2, 80, 3, 4, 4, 24'h2, 24'h2);
    chk("fill_x80_ready", 64'(cmd_ready), 64'(1));

    // CLEAR with a SETCURSOR held pending while busy
    run("setcur_pre", 0, 40, 12, 0, 0, '0, '0);
    act.delete();
    exp_q.delete();
    model(3, 0, 0, 0, 0);
    send(3, 0, 0, 0, 0, 24'h000020, 24'hFFFF00);
    cmd_op = 2'd0; cmd_x = 16'd10; cmd_y = 16'd10; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      chk("clear_hold_busy", 64'(busy), 64'(!cmd_ready));
      step();
      n++;
    end
    compare("clear", 24'h000020, 24'hFFFF00, 1'b1);
    step();
    cmd_valid = 1'b0;
    model(0, 10, 10, 0, 0);
    chk("held_cursor", 64'({cursor_x, cursor_y}), 64'({16'(m_cx), 16'(m_cy)}));

    // Reset in the middle of a CLEAR
    act.delete();
    exp_q.delete();
    send(3, 0, 0, 0, 0, 24'h55AA55, 24'hFFFFFF);
    repeat (100) step();
    chk("midclr_writes", 64'(act.size()), 64'(100));
    if (act.size() == 100) chk("midclr_last_addr", 64'(act[99].addr), 64'(99));
    reset = 1'b0;
    #1;
    chk("midclr_write", 64'(video_write), 64'(0));
    chk("midclr_cursor", 64'({cursor_x, cursor_y}), 64'(0));
    chk("midclr_ready", 64'(cmd_ready), 64'(1));
    chk("midclr_busy", 64'(busy), 64'(0));
    step();
    reset = 1'b1;
    m_cx = 0;
    m_cy = 0;
    act.delete();
    repeat (50) step();
    chk("midclr_after", 64'(act.size()), 64'(0));

    // Random command mix
    for (int t = 0; t < 60; t++) begin
      int op, x, y, w, h;
      op = $urandom_range(0, 3);
      if (op == 3 && $urandom_range(0, 3) != 0) op = 2;
      x = $urandom_range(0, 85);
      y = $urandom_range(0, 28);
      if ($urandom_range(0, 9) == 0) x = $urandom_range(0, 65535);
      if ($urandom_range(0, 9) == 0) y = $urandom_range(0, 65535);
      w = $urandom_range(0, 10);
      h = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) w = $urandom_range(0, 65535);
      if ($urandom_range(0, 9) == 0) h = $urandom_range(0, 65535);
      rv = AW'($urandom);
      rm = AW'($urandom);
      run($sformatf("rnd%0d_op%0d", t, op), op, x, y, w, h, rv, rm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule
